dac_spi_tx: RTL and testbench
=============================

Name: dac_spi_tx

Overview:
- Downstream of the arbitrary-waveform generator: takes each 16-bit sample it produces and serialises it to an external SPI DAC (command byte + sample word), then pulses LDAC_N to latch the output.
- Ready/valid handshake on the sample side, so the generator (or a rate divider in front of it) can stall while a frame is in flight.
- Generates all SPI timing (SCLK, CS_N, MOSI, LDAC_N) from the single system clock.

Parameters:
- DATA_WIDTH, 16, sample width; matches the generator output.
- CMD_WIDTH, 8, command prefix width sent before the sample.
- CLK_DIV, 4, SCLK half-period and every phase length, in clk cycles; legal range 1..255.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous active-low reset.
- in_data  input  DATA_WIDTH  sample from the wave generator.
- in_cmd  input  CMD_WIDTH  DAC command/address bits; sampled together with in_data.
- in_valid  input  1  in_data/in_cmd valid.
- in_ready  output  1  block can accept a sample this cycle.
- dac_sclk  output  1  SPI clock, idle low (mode 0).
- dac_cs_n  output  1  chip select, active low.
- dac_mosi  output  1  serial data, MSB first.
- dac_ldac_n  output  1  load-DAC strobe, active low.
- busy  output  1  frame in progress (state != IDLE).
- frame_done  output  1  one-cycle pulse when a frame fully completes.

Behaviour:
- Reset: reset_n=0 on a rising clk edge. Result: state=IDLE, in_ready=1, dac_sclk=0, dac_cs_n=1, dac_mosi=0, dac_ldac_n=1, busy=0, frame_done=0, and the shift register and counters are cleared. Reset mid-frame aborts the frame immediately; the DAC sees CS_N rise without LDAC.
- FRAME = CMD_WIDTH+DATA_WIDTH bits (default 24).
- in_ready is 1 only in IDLE, so no sample is accepted while busy. A sample offered while busy is held by the source; nothing is dropped.
- Acceptance (IDLE, in_valid=1, in_ready=1):
  - Latch {in_cmd,in_data} into a FRAME-bit shift register.
  - Next state SETUP. dac_cs_n goes 0 and dac_mosi = frame MSB on the following cycle.
- States:
  - IDLE.
  - SETUP: CLK_DIV cycles. cs_n=0, sclk=0, mosi=bit FRAME-1.
  - SHIFT: per bit, sclk=1 for CLK_DIV cycles, then sclk=0 for CLK_DIV cycles. mosi changes only on sclk falling transitions, to the next bit. Bit counter counts FRAME bits. After the low half of the last bit, go to HOLD.
  - HOLD: CLK_DIV cycles. cs_n=0, sclk=0.
  - LDAC: CLK_DIV cycles. cs_n=1, ldac_n=0.
  - Then IDLE. frame_done=1 for exactly the first IDLE cycle.
- Timing:
  - Frame length from acceptance edge to return to IDLE is CLK_DIV*(2*FRAME+3) cycles; 204 with defaults.
  - Back-to-back: a sample held valid is accepted on the same cycle frame_done pulses, giving a maximum rate of 1 sample per CLK_DIV*(2*FRAME+3)+1 cycles.
  - dac_ldac_n never goes low while dac_cs_n=0.
- All outputs are registered, with no combinational path from inputs to SPI pins. in_ready is a decode of registered state.
- Phase counter width is 8 bits; bit counter is wide enough for FRAME.
- CLK_DIV=1 is legal: sclk toggles every clk cycle.

Optional Feature:
- Macro: DAC_SPI_TX_OFFSET_BIN_EN.
- Defined: in_data is treated as two's complement (the generator's signed sine). The MSB of the data field is inverted when latched, giving offset binary for unipolar DACs. The command field is unaffected.
- Undefined: data is shifted out unmodified.
- Timing is identical in both builds.

Test Plan:
- Reset mid-SHIFT: assert reset_n=0 during bit 10 of a frame. Next edge: cs_n=1, sclk=0, ldac_n=1, in_ready=1, busy=0, and no frame_done pulse.
- Single frame, defaults: in_cmd=8'h30, in_data=16'hA5C3, one-cycle valid.
  - Captured MOSI on sclk rising edges is 24'h30A5C3, MSB first.
  - 24 sclk pulses, each high 4 and low 4 cycles.
  - ldac_n low 4 cycles after cs_n rises.
  - frame_done 204 cycles after acceptance.
- Back-pressure: hold in_valid=1 with data 16'h0001 then 16'hFFFF.
  - in_ready=0 throughout frame 1.
  - Second sample accepted on the frame_done cycle, with no gap and no loss.
  - Two complete frames.
- CLK_DIV=1: in_data=16'h8001. Frame lasts 51 cycles; sclk toggles every cycle; MOSI is correct on every rising edge.
- Macro defined: in_data=16'h0000 gives 16'h8000 on the wire; 16'h7FFF gives 16'hFFFF; in_cmd bits are unchanged.
- Protocol checker over 1000 random samples with random valid gaps:
  - ldac_n low never overlaps cs_n low.
  - mosi stable while sclk=1.
  - Exactly one frame_done per accepted sample.

Source files
------------

// File: rtl/dac_spi_tx.sv
// Serialises {cmd, sample} frames to an SPI DAC (mode 0, MSB first) and strobes LDAC_N afterwards.
// Build option: define DAC_SPI_TX_OFFSET_BIN_EN to convert two's-complement samples to offset binary.
module dac_spi_tx #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CMD_WIDTH  = 8,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CMD_WIDTH-1:0]  in_cmd,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  dac_sclk,
    output logic                  dac_cs_n,
    output logic                  dac_mosi,
    output logic                  dac_ldac_n,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned FRAME = CMD_WIDTH + DATA_WIDTH;
    localparam int unsigned BIT_W = $clog2(FRAME);
    localparam logic [7:0]       PH_LAST  = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_LDAC
    } state_t;

    state_t             state;
    logic [7:0]         phase;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME-1:0]   shreg;
    logic [DATA_WIDTH-1:0] data_fmt;
    logic [FRAME-1:0]   frame_word;
    logic               phase_done;

`ifdef DAC_SPI_TX_OFFSET_BIN_EN
    assign data_fmt = {~in_data[DATA_WIDTH-1], in_data[DATA_WIDTH-2:0]};
`else
    assign data_fmt = in_data;
`endif

    assign frame_word = {in_cmd, data_fmt};
    assign phase_done = (phase == PH_LAST);
    assign in_ready   = (state == S_IDLE);
    assign busy       = (state != S_IDLE);

    // Frame sequencer; every SPI pin is driven from this register block.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            phase      <= 8'd0;
            bit_cnt    <= '0;
            shreg      <= '0;
            dac_sclk   <= 1'b0;
            dac_cs_n   <= 1'b1;
            dac_mosi   <= 1'b0;
            dac_ldac_n <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg    <= frame_word;
                        dac_mosi <= frame_word[FRAME-1];
                        dac_cs_n <= 1'b0;
                        phase    <= 8'd0;
                        bit_cnt  <= '0;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase_done) begin
                        phase    <= 8'd0;
                        dac_sclk <= 1'b1;
                        state    <= S_SHIFT;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (phase_done) begin
                        phase <= 8'd0;
                        // Data advances on the falling edge so it is stable across the next rise.
                        if (dac_sclk) begin
                            dac_sclk <= 1'b0;
                            if (bit_cnt != BIT_LAST) begin
                                shreg    <= shreg << 1;
                                dac_mosi <= shreg[FRAME-2];
                            end
                        end else if (bit_cnt == BIT_LAST) begin
                            state <= S_HOLD;
                        end else begin
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            dac_sclk <= 1'b1;
                        end
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (phase_done) begin
                        phase      <= 8'd0;
                        dac_cs_n   <= 1'b1;
                        dac_ldac_n <= 1'b0;
                        state      <= S_LDAC;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                S_LDAC: begin
                    if (phase_done) begin
                        phase      <= 8'd0;
                        dac_ldac_n <= 1'b1;
                        dac_mosi   <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: instance 0 uses CLK_DIV=4, instance 1 uses CLK_DIV=1.
module tb_dac_spi_tx;

`ifdef DAC_SPI_TX_OFFSET_BIN_EN
    localparam logic [15:0] FLIP = 16'h8000;
`else
    localparam logic [15:0] FLIP = 16'h0000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n    [2];
    logic [15:0] in_data    [2];
    logic [7:0]  in_cmd     [2];
    logic        in_valid   [2];
    logic        in_ready   [2];
    logic        dac_sclk   [2];
    logic        dac_cs_n   [2];
    logic        dac_mosi   [2];
    logic        dac_ldac_n [2];
    logic        busy       [2];
    logic        frame_done [2];

    dac_spi_tx #(.DATA_WIDTH(16), .CMD_WIDTH(8), .CLK_DIV(4)) u_dut0 (
        .clk(clk), .reset_n(reset_n[0]), .in_data(in_data[0]), .in_cmd(in_cmd[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .dac_sclk(dac_sclk[0]),
        .dac_cs_n(dac_cs_n[0]), .dac_mosi(dac_mosi[0]), .dac_ldac_n(dac_ldac_n[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    dac_spi_tx #(.DATA_WIDTH(16), .CMD_WIDTH(8), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n[1]), .in_data(in_data[1]), .in_cmd(in_cmd[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .dac_sclk(dac_sclk[1]),
        .dac_cs_n(dac_cs_n[1]), .dac_mosi(dac_mosi[1]), .dac_ldac_n(dac_ldac_n[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cd(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Reference: the wire carries the command then the (optionally offset-binary) sample.
    function automatic logic [23:0] model(input logic [7:0] c, input logic [15:0] d);
        return {c, d ^ FLIP};
    endfunction

    // Monitor / scoreboard state, one slot per instance (at most one frame in flight each).
    logic        prev_sclk [2];
    logic        prev_mosi [2];
    logic [23:0] cap       [2];
    logic [23:0] last_word [2];
    logic [23:0] pend_w    [2];
    logic        pend      [2];
    int          nbits     [2];
    int          hi_len    [2];
    int          viol      [2];
    int          pend_cyc  [2];
    int          acc_cnt   [2];
    int          done_cnt  [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n[i]) begin
                pend[i] = 1'b0; nbits[i] = 0; cap[i] = '0; viol[i] = 0;
                prev_sclk[i] = 1'b0; prev_mosi[i] = 1'b0; hi_len[i] = 0;
            end else begin
                if (!dac_ldac_n[i] && !dac_cs_n[i]) viol[i]++;
                if (dac_sclk[i] && dac_cs_n[i]) viol[i]++;
                if (busy[i] !== (pend[i] && !frame_done[i])) viol[i]++;
                if (in_ready[i] !== !busy[i]) viol[i]++;
                if (dac_sclk[i] && !prev_sclk[i]) begin
                    cap[i] = {cap[i][22:0], dac_mosi[i]};
                    nbits[i]++;
                    hi_len[i] = 1;
                end else if (dac_sclk[i] && prev_sclk[i]) begin
                    hi_len[i]++;
                    if (dac_mosi[i] !== prev_mosi[i]) viol[i]++;
                end else if (!dac_sclk[i] && prev_sclk[i]) begin
                    if (hi_len[i] != cd(i)) viol[i]++;
                end
                if (frame_done[i]) begin
                    check($sformatf("done_has_accept_%0d", i), 32'(pend[i]), 32'd1);
                    check($sformatf("wire_word_%0d", i), 32'(cap[i]), 32'(pend_w[i]));
                    check($sformatf("sclk_pulses_%0d", i), 32'(nbits[i]), 32'd24);
                    check($sformatf("latency_%0d", i), 32'(cyc - pend_cyc[i]), 32'(cd(i) * 51));
                    check($sformatf("protocol_%0d", i), 32'(viol[i]), 32'd0);
                    last_word[i] = cap[i];
                    done_cnt[i]++;
                    pend[i] = 1'b0; nbits[i] = 0; cap[i] = '0; viol[i] = 0;
                end
                if (in_valid[i] && in_ready[i]) begin
                    pend[i]     = 1'b1;
                    pend_w[i]   = model(in_cmd[i], in_data[i]);
                    pend_cyc[i] = cyc + 1;
                    acc_cnt[i]++;
                end
                prev_sclk[i] = dac_sclk[i];
                prev_mosi[i] = dac_mosi[i];
            end
        end
    end

    // Offer one sample and hold it until the next edge accepts it.
    task automatic send_one(input int i, input logic [7:0] c, input logic [15:0] d);
        bit ok = 1'b0;
        @(posedge clk); #1;
        in_cmd[i] = c; in_data[i] = d; in_valid[i] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (in_ready[i]) begin ok = 1'b1; break; end
        end
        if (!ok) check($sformatf("accept_timeout_%0d", i), 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (frame_done[i]) begin seen = 1'b1; break; end
        end
        if (!seen) check($sformatf("done_timeout_%0d", i), 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        logic [23:0] wire_word;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int d0;
        int acc0;
        int done1;
        int toggles;
        int k;
        logic ps;

`ifdef DAC_SPI_TX_OFFSET_BIN_EN
        vecs[0] = '{8'h30, 16'hA5C3, 24'h3025C3};
        vecs[1] = '{8'h00, 16'h0000, 24'h008000};
        vecs[2] = '{8'hFF, 16'h7FFF, 24'hFFFFFF};
        vecs[3] = '{8'h5A, 16'h8001, 24'h5A0001};
`else
        vecs[0] = '{8'h30, 16'hA5C3, 24'h30A5C3};
        vecs[1] = '{8'h00, 16'h0000, 24'h000000};
        vecs[2] = '{8'hFF, 16'h7FFF, 24'hFF7FFF};
        vecs[3] = '{8'h5A, 16'h8001, 24'h5A8001};
`endif

        for (int i = 0; i < 2; i++) begin
            reset_n[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0; in_cmd[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_in_ready_%0d", i), 32'(in_ready[i]), 32'd1);
            check($sformatf("rst_sclk_%0d", i), 32'(dac_sclk[i]), 32'd0);
            check($sformatf("rst_cs_n_%0d", i), 32'(dac_cs_n[i]), 32'd1);
            check($sformatf("rst_mosi_%0d", i), 32'(dac_mosi[i]), 32'd0);
            check($sformatf("rst_ldac_n_%0d", i), 32'(dac_ldac_n[i]), 32'd1);
            check($sformatf("rst_busy_%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("rst_frame_done_%0d", i), 32'(frame_done[i]), 32'd0);
        end
        @(posedge clk); #1;
        reset_n[0] = 1'b1; reset_n[1] = 1'b1;

        // Single frames with one-cycle valid on the default-divider instance.
        for (int v = 0; v < 4; v++) begin
            send_one(0, vecs[v].cmd, vecs[v].data);
            wait_done(0, 300);
            @(posedge clk); #1;
            check($sformatf("table_word_%0d", v), 32'(last_word[0]), 32'(vecs[v].wire_word));
        end

        // Back-pressure: second sample held valid through the whole first frame.
        @(posedge clk); #1;
        in_cmd[0] = 8'h11; in_data[0] = 16'h0001; in_valid[0] = 1'b1;
        k = 0;
        while (!in_ready[0] && k < 10) begin @(negedge clk); k++; end
        @(negedge clk);
        @(posedge clk); #1;
        in_cmd[0] = 8'h22; in_data[0] = 16'hFFFF;
        acc0 = 0; done1 = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (frame_done[0]) begin done1 = cyc; break; end
            if (in_ready[0]) acc0++;
        end
        check("bp_ready_low_in_frame", 32'(acc0), 32'd0);
        check("bp_ready_on_done", 32'(in_ready[0]), 32'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("bp_first_word", 32'(last_word[0]), 32'(model(8'h11, 16'h0001)));
        wait_done(0, 300);
        check("bp_period", 32'(cyc - done1), 32'd205);
        @(posedge clk); #1;
        check("bp_second_word", 32'(last_word[0]), 32'(model(8'h22, 16'hFFFF)));

        // Reset during bit 10 aborts the frame with no LDAC and no completion.
        send_one(0, 8'h30, 16'hA5C3);
        k = 0;
        while (nbits[0] < 10 && k < 300) begin @(negedge clk); k++; end
        check("rst_mid_reached_bit10", 32'(nbits[0] >= 10), 32'd1);
        @(posedge clk); #1;
        reset_n[0] = 1'b0;
        d0 = done_cnt[0];
        @(posedge clk);
        @(negedge clk);
        check("abort_cs_n", 32'(dac_cs_n[0]), 32'd1);
        check("abort_sclk", 32'(dac_sclk[0]), 32'd0);
        check("abort_ldac_n", 32'(dac_ldac_n[0]), 32'd1);
        check("abort_in_ready", 32'(in_ready[0]), 32'd1);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_frame_done", 32'(frame_done[0]), 32'd0);
        @(posedge clk); #1;
        reset_n[0] = 1'b1;
        repeat (300) @(negedge clk);
        check("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);

        // CLK_DIV=1: sclk toggles every cycle, frame lasts 51 cycles.
        send_one(1, 8'hA6, 16'h8001);
        k = 0; toggles = 0; ps = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (frame_done[1]) break;
            if (dac_sclk[1] !== ps) toggles++;
            ps = dac_sclk[1];
            k++;
        end
        check("div1_frame_cycles", 32'(k), 32'd51);
        check("div1_sclk_toggles", 32'(toggles), 32'd48);
        @(posedge clk); #1;
`ifdef DAC_SPI_TX_OFFSET_BIN_EN
        check("div1_word", 32'(last_word[1]), 32'h00A60001);
`else
        check("div1_word", 32'(last_word[1]), 32'h00A68001);
`endif

        // Random samples with random idle gaps; the monitor checks every frame.
        acc0 = acc_cnt[1];
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_one(1, 8'($urandom), 16'($urandom));
        end
        wait_done(1, 200);
        @(posedge clk); #1;
        check("rand_accepted", 32'(acc_cnt[1] - acc0), 32'd1000);
        check("rand_done_per_accept", 32'(done_cnt[1]), 32'(acc_cnt[1]));
        check("rand_none_pending", 32'(pend[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
